// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel window fetch path.
//   state_t : top-level fetch FSM states
//   rd_t    : phases of a single pixel read transaction
//   DIR_*   : shift_direc encodings sent to the window buffer
//   PIX_W   : pixel width in bits
// ---------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_SHIFT,
        ST_FILL,
        ST_DONE
    } state_t;

    // RD_SETUP gives the registered address generator one cycle to settle
    // so mem_addr is already stable on the first cycle mem_ren is high.
    typedef enum logic [1:0] {
        RD_SETUP,
        RD_REQ,
        RD_DATA,
        RD_ACK
    } rd_t;

    localparam logic [1:0] DIR_LOAD  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

endpackage

// File: rtl/pixel_addr_gen.sv
// ---------------------------------------------------------------------------
// pixel_addr_gen
// Converts a pixel (row, col) into a linear memory address
// base + row*IMG_W + col, registered.
//   clk, n_rst : clock, async active-low reset (output clears to 0)
//   i_en       : capture the new address this cycle
//   i_base     : frame base address
//   i_row/i_col: pixel coordinates
//   o_addr     : registered address, holds while i_en is low
// ---------------------------------------------------------------------------
module pixel_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [15:0]       i_row,
    input  logic [15:0]       i_col,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] LP_W = ADDR_W'(IMG_W);

    logic [ADDR_W-1:0] w_addr;

    assign w_addr = i_base + ADDR_W'(i_row) * LP_W + ADDR_W'(i_col);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            o_addr <= '0;
        else if (i_en)
            o_addr <= w_addr;
    end

endmodule

// File: rtl/window_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// window_fetch_ctrl
// Walks a 3x3 window over an IMG_W x IMG_H image in serpentine order,
// fetching pixels one at a time and steering a 3x3 window buffer.
//   clk, n_rst        : clock, async active-low reset
//   start, base_addr  : begin a frame at base_addr (only when idle)
//   busy, frame_done  : frame in progress / one-cycle end-of-frame pulse
//   mem_*             : single-outstanding pixel read port
//   start_read, data_r, read_done   : pixel delivery to window buffer
//   start_shift, shift_direc, shift_done : window shift command
//   window_valid/ready, center_row/col   : window handoff to Sobel stage
// ---------------------------------------------------------------------------
module window_fetch_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic              start_read,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    output logic [PIX_W-1:0]  data_r,
    input  logic              read_done,
    input  logic              shift_done,
    output logic              window_valid,
    input  logic              window_ready,
    output logic [15:0]       center_row,
    output logic [15:0]       center_col
);

    localparam logic [15:0] LP_LAST_COL = 16'(IMG_W - 2);
    localparam logic [15:0] LP_LAST_ROW = 16'(IMG_H - 2);

    state_t             r_state, w_state_n;
    rd_t                r_rd, w_rd_n;
    logic [ADDR_W-1:0]  r_base, w_base_n;
    logic [15:0]        r_crow, w_crow_n;
    logic [15:0]        r_ccol, w_ccol_n;
    logic [1:0]         r_sub, w_sub_n;     // index within a row/column of 3
    logic [1:0]         r_grp, w_grp_n;     // LOAD row index
    logic [1:0]         r_dir, w_dir_n;
    logic               r_pass, w_pass_n;   // 0: moving right, 1: moving left
    logic [PIX_W-1:0]   r_data, w_data_n;
    logic               r_sent, w_sent_n;   // start_shift already issued

    logic               w_rd_act;
    logic               w_adv;
    logic [15:0]        w_frow, w_fcol;

    assign w_rd_act = (r_state == ST_LOAD) || (r_state == ST_FILL);

    // Coordinates of the pixel currently being fetched. During FILL the
    // centre still holds the pre-shift position; it moves once the fill
    // completes.
    always_comb begin
        w_frow = '0;
        w_fcol = '0;
        if (r_state == ST_LOAD) begin
            w_frow = {14'd0, r_grp};
            w_fcol = {14'd0, r_sub};
        end else begin
            case (r_dir)
                DIR_RIGHT: begin
                    w_frow = r_crow - 16'd1 + {14'd0, r_sub};
                    w_fcol = r_ccol + 16'd2;
                end
                DIR_LEFT: begin
                    w_frow = r_crow - 16'd1 + {14'd0, r_sub};
                    w_fcol = r_ccol - 16'd2;
                end
                default: begin
                    w_frow = r_crow + 16'd2;
                    w_fcol = r_ccol - 16'd1 + {14'd0, r_sub};
                end
            endcase
        end
    end

    pixel_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_en   (w_rd_act && (r_rd == RD_SETUP)),
        .i_base (r_base),
        .i_row  (w_frow),
        .i_col  (w_fcol),
        .o_addr (mem_addr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_rd    <= RD_SETUP;
            r_base  <= '0;
            r_crow  <= '0;
            r_ccol  <= '0;
            r_sub   <= '0;
            r_grp   <= '0;
            r_dir   <= DIR_LOAD;
            r_pass  <= 1'b0;
            r_data  <= '0;
            r_sent  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rd    <= w_rd_n;
            r_base  <= w_base_n;
            r_crow  <= w_crow_n;
            r_ccol  <= w_ccol_n;
            r_sub   <= w_sub_n;
            r_grp   <= w_grp_n;
            r_dir   <= w_dir_n;
            r_pass  <= w_pass_n;
            r_data  <= w_data_n;
            r_sent  <= w_sent_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_rd_n    = r_rd;
        w_base_n  = r_base;
        w_crow_n  = r_crow;
        w_ccol_n  = r_ccol;
        w_sub_n   = r_sub;
        w_grp_n   = r_grp;
        w_dir_n   = r_dir;
        w_pass_n  = r_pass;
        w_data_n  = r_data;
        w_sent_n  = r_sent;
        w_adv     = 1'b0;

        // Single-outstanding read engine shared by LOAD and FILL.
        if (w_rd_act) begin
            case (r_rd)
                RD_SETUP: w_rd_n = RD_REQ;
                RD_REQ: begin
                    if (mem_rvalid) begin
                        w_data_n = mem_rdata;
                        w_rd_n   = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (read_done) w_adv = 1'b1;
                    else           w_rd_n = RD_ACK;
                end
                default: begin
                    if (read_done) w_adv = 1'b1;
                end
            endcase
            if (w_adv) w_rd_n = RD_SETUP;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_LOAD;
                    w_rd_n    = RD_SETUP;
                    w_base_n  = base_addr;
                    w_sub_n   = '0;
                    w_grp_n   = '0;
                    w_dir_n   = DIR_LOAD;
                    w_pass_n  = 1'b0;
                    w_crow_n  = '0;
                    w_ccol_n  = '0;
                end
            end
            ST_LOAD: begin
                if (w_adv) begin
                    if (r_sub == 2'd2) begin
                        w_sub_n = '0;
                        if (r_grp == 2'd2) begin
                            w_grp_n   = '0;
                            w_state_n = ST_EMIT;
                            w_crow_n  = 16'd1;
                            w_ccol_n  = 16'd1;
                        end else begin
                            w_grp_n = r_grp + 2'd1;
                        end
                    end else begin
                        w_sub_n = r_sub + 2'd1;
                    end
                end
            end
            ST_EMIT: begin
                if (window_ready) begin
                    w_sent_n  = 1'b0;
                    w_state_n = ST_SHIFT;
                    if (!r_pass && (r_ccol < LP_LAST_COL)) begin
                        w_dir_n = DIR_RIGHT;
                    end else if (r_pass && (r_ccol > 16'd1)) begin
                        w_dir_n = DIR_LEFT;
                    end else if (r_crow == LP_LAST_ROW) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_dir_n  = DIR_DOWN;
                        w_pass_n = ~r_pass;
                    end
                end
            end
            ST_SHIFT: begin
                w_sent_n = 1'b1;
                if (shift_done) begin
                    w_state_n = ST_FILL;
                    w_rd_n    = RD_SETUP;
                    w_sub_n   = '0;
                end
            end
            ST_FILL: begin
                if (w_adv) begin
                    if (r_sub == 2'd2) begin
                        w_sub_n   = '0;
                        w_state_n = ST_EMIT;
                        case (r_dir)
                            DIR_RIGHT: w_ccol_n = r_ccol + 16'd1;
                            DIR_LEFT:  w_ccol_n = r_ccol - 16'd1;
                            default:   w_crow_n = r_crow + 16'd1;
                        endcase
                    end else begin
                        w_sub_n = r_sub + 2'd1;
                    end
                end
            end
            ST_DONE:  w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign frame_done   = (r_state == ST_DONE);
    assign mem_ren      = w_rd_act && (r_rd == RD_REQ);
    assign start_read   = w_rd_act && (r_rd == RD_DATA);
    assign start_shift  = (r_state == ST_SHIFT) && !r_sent;
    assign shift_direc  = r_dir;
    assign data_r       = r_data;
    assign window_valid = (r_state == ST_EMIT);
    assign center_row   = r_crow;
    assign center_col   = r_ccol;

endmodule
